// File: rtl/led_matrix_pkg.sv
// Shared types and sizes for the LED matrix serial front-end and row writer.
package led_matrix_pkg;

  localparam int unsigned COLS   = 8;
  localparam int unsigned ADDR_W = 3;
  localparam int unsigned WORD_W = ADDR_W + COLS;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [COLS-1:0]   data;
  } row_word_t;

  typedef enum logic {
    OS_EMPTY,
    OS_FULL
  } out_state_t;

endpackage

// File: rtl/led_serial_rx_if.sv
// Valid/ready row-write channel from the serial receiver to the frame buffer.
interface led_serial_rx_if;
  import led_matrix_pkg::*;

  logic              wr_valid;
  logic              wr_ready;
  logic [ADDR_W-1:0] wr_addr;
  logic [COLS-1:0]   wr_data;

  modport master (output wr_valid, output wr_addr, output wr_data, input wr_ready);
  modport slave  (input wr_valid, input wr_addr, input wr_data, output wr_ready);

endinterface

// File: rtl/led_sync_edge.sv
// Multi-flop synchroniser for an asynchronous pin with a registered rising-edge pulse.
module led_sync_edge #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic pin,
  output logic level,
  output logic rise
);

  logic [SYNC_STAGES-1:0] chain_q;
  logic                   prev_q;
  logic                   rise_q;

  // Shift the pin through the chain; the edge pulse is one register past the synchronised level.
  always_ff @(posedge clk) begin
    if (rst) begin
      chain_q <= '0;
      prev_q  <= 1'b0;
      rise_q  <= 1'b0;
    end else begin
      chain_q <= {chain_q[SYNC_STAGES-2:0], pin};
      prev_q  <= chain_q[SYNC_STAGES-1];
      rise_q  <= chain_q[SYNC_STAGES-1] & ~prev_q;
    end
  end

  assign level = chain_q[SYNC_STAGES-1];
  assign rise  = rise_q;

endmodule

// File: rtl/led_serial_rx.sv
// Serial row-word receiver: shifts din on dclk, commits {addr, data} on strobe
// as a single valid/ready write, with sticky framing and overflow flags.
module led_serial_rx
  import led_matrix_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   ena,
  input  logic                   din,
  input  logic                   dclk,
  input  logic                   strobe,
  input  logic                   err_clr,
  led_serial_rx_if.master        wr,
  output logic                   frame_err,
  output logic                   overflow
);

  localparam int unsigned       CNT_W    = $clog2(WORD_W + 2);
  localparam logic [CNT_W-1:0]  CNT_WORD = CNT_W'(WORD_W);
  localparam logic [CNT_W-1:0]  CNT_SAT  = CNT_W'(WORD_W + 1);

  logic din_lvl;
  logic din_rise_unused;
  logic dclk_lvl_unused;
  logic dclk_rise;
  logic strobe_lvl_unused;
  logic strobe_rise;

  led_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_din (
    .clk   (clk),
    .rst   (rst),
    .pin   (din),
    .level (din_lvl),
    .rise  (din_rise_unused)
  );

  led_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_dclk (
    .clk   (clk),
    .rst   (rst),
    .pin   (dclk),
    .level (dclk_lvl_unused),
    .rise  (dclk_rise)
  );

  led_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_strobe (
    .clk   (clk),
    .rst   (rst),
    .pin   (strobe),
    .level (strobe_lvl_unused),
    .rise  (strobe_rise)
  );

  out_state_t        state_q,     state_n;
  logic [WORD_W-1:0] sreg_q,      sreg_n;
  logic [CNT_W-1:0]  cnt_q,       cnt_n;
  row_word_t         word_q,      word_n;
  logic              valid_q;
  logic              frame_err_q, frame_err_n;
  logic              overflow_q,  overflow_n;
  logic              word_ok_c;
  logic              accept_c;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= OS_EMPTY;
      sreg_q      <= '0;
      cnt_q       <= '0;
      word_q      <= '0;
      valid_q     <= 1'b0;
      frame_err_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_n;
      sreg_q      <= sreg_n;
      cnt_q       <= cnt_n;
      word_q      <= word_n;
      valid_q     <= (state_n == OS_FULL);
      frame_err_q <= frame_err_n;
      overflow_q  <= overflow_n;
    end
  end

  // Shift first, then judge a coincident strobe against the updated count and word.
  always_comb begin
    state_n     = state_q;
    sreg_n      = sreg_q;
    cnt_n       = cnt_q;
    word_n      = word_q;
    frame_err_n = frame_err_q & ~err_clr;
    overflow_n  = overflow_q & ~err_clr;
    word_ok_c   = 1'b0;
    accept_c    = (state_q == OS_FULL) && wr.wr_ready;

    if (ena && dclk_rise) begin
      sreg_n = {sreg_q[WORD_W-2:0], din_lvl};
      if (cnt_q != CNT_SAT) cnt_n = cnt_q + CNT_W'(1);
    end

    if (ena && strobe_rise) begin
      word_ok_c = (cnt_n == CNT_WORD);
      if (!word_ok_c) frame_err_n = 1'b1;
      cnt_n = '0;
    end

    // Output slot: a held word stays put until accepted; new words reload only into a free slot.
    case (state_q)
      OS_EMPTY: begin
        if (word_ok_c) begin
          state_n = OS_FULL;
          word_n  = row_word_t'(sreg_n);
        end
      end
      OS_FULL: begin
        if (accept_c) begin
          if (word_ok_c) word_n  = row_word_t'(sreg_n);
          else           state_n = OS_EMPTY;
        end else if (word_ok_c) begin
          overflow_n = 1'b1;
        end
      end
      default: state_n = OS_EMPTY;
    endcase
  end

  assign wr.wr_valid = valid_q;
  assign wr.wr_addr  = word_q.addr;
  assign wr.wr_data  = word_q.data;
  assign frame_err   = frame_err_q;
  assign overflow    = overflow_q;

endmodule

// File: tb/tb_led_serial_rx.sv
// Directed bench for led_serial_rx: table of serial words plus handshake/reset/enable corner cases.
module tb_led_serial_rx;
  import led_matrix_pkg::*;

  localparam int unsigned SYNC_STAGES = 2;
  localparam int unsigned HOLD        = SYNC_STAGES + 2;

  logic clk = 1'b0;
  logic rst, ena, din, dclk, strobe, err_clr;
  logic frame_err, overflow;

  led_serial_rx_if wr ();

  led_serial_rx #(.SYNC_STAGES(SYNC_STAGES)) dut (
    .clk       (clk),
    .rst       (rst),
    .ena       (ena),
    .din       (din),
    .dclk      (dclk),
    .strobe    (strobe),
    .err_clr   (err_clr),
    .wr        (wr.master),
    .frame_err (frame_err),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  row_word_t wq[$];

  // Record every write the downstream side will accept at the next rising edge.
  always @(negedge clk) begin
    if (!rst && wr.wr_valid && wr.wr_ready) wq.push_back({wr.wr_addr, wr.wr_data});
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [15:0] bits;
    int          nbits;
    bit          exp_wr;
    logic [2:0]  exp_addr;
    logic [7:0]  exp_data;
    bit          exp_ferr;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic check_wq(input string name, input int idx, input row_word_t exp);
    if (idx < wq.size()) begin
      check(name, 32'(wq[idx]), 32'(exp));
    end else begin
      tests++;
      fails++;
      $display("FAIL %s: no write recorded, expected %0h", name, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    din = b;
    cyc(HOLD);
    dclk = 1'b1;
    cyc(HOLD);
    dclk = 1'b0;
    cyc(HOLD);
  endtask

  task automatic send_bits(input logic [15:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) send_bit(v[i]);
  endtask

  task automatic pulse_strobe();
    strobe = 1'b1;
    cyc(HOLD);
    strobe = 1'b0;
    cyc(HOLD);
  endtask

  task automatic clear_err();
    err_clr = 1'b1;
    cyc(1);
    err_clr = 1'b0;
    cyc(1);
  endtask

  vec_t vecs[8];
  int   lat;

  initial begin
    vecs[0] = '{16'h05CA, 11, 1'b1, 3'd5, 8'hCA, 1'b0};
    vecs[1] = '{16'h010F, 11, 1'b1, 3'd1, 8'h0F, 1'b0};
    vecs[2] = '{16'h07FF, 11, 1'b1, 3'd7, 8'hFF, 1'b0};
    vecs[3] = '{16'h0000, 11, 1'b1, 3'd0, 8'h00, 1'b0};
    vecs[4] = '{16'h02A5, 11, 1'b1, 3'd2, 8'hA5, 1'b0};
    vecs[5] = '{16'h02AA, 10, 1'b0, 3'd0, 8'h00, 1'b1};
    vecs[6] = '{16'h0ABC, 12, 1'b0, 3'd0, 8'h00, 1'b1};
    vecs[7] = '{16'h0000,  0, 1'b0, 3'd0, 8'h00, 1'b1};

    rst = 1'b1; ena = 1'b1; din = 1'b0; dclk = 1'b0; strobe = 1'b0; err_clr = 1'b0;
    wr.wr_ready = 1'b1;
    cyc(3);
    check("reset wr_valid", 32'(wr.wr_valid), 0);
    check("reset wr_addr", 32'(wr.wr_addr), 0);
    check("reset wr_data", 32'(wr.wr_data), 0);
    check("reset frame_err", 32'(frame_err), 0);
    check("reset overflow", 32'(overflow), 0);
    rst = 1'b0;
    cyc(2);

    // Basic word with latency and single-cycle pulse.
    send_bits(16'h05CA, 11);
    strobe = 1'b1;
    lat = 0;
    for (int k = 1; k <= 10 && lat == 0; k++) begin
      cyc(1);
      if (wr.wr_valid) lat = k;
    end
    check("t1 latency", 32'(lat), 32'(HOLD));
    check("t1 addr", 32'(wr.wr_addr), 5);
    check("t1 data", 32'(wr.wr_data), 32'h0CA);
    cyc(1);
    check("t1 pulse width", 32'(wr.wr_valid), 0);
    strobe = 1'b0;
    cyc(HOLD);
    check("t1 write count", 32'(wq.size()), 1);
    check_wq("t1 write", 0, row_word_t'(11'h5CA));
    check("t1 frame_err", 32'(frame_err), 0);
    check("t1 overflow", 32'(overflow), 0);
    wq.delete();

    // Table of word lengths and patterns.
    foreach (vecs[i]) begin
      send_bits(vecs[i].bits, vecs[i].nbits);
      pulse_strobe();
      cyc(4);
      check($sformatf("vec%0d write count", i), 32'(wq.size()), 32'(vecs[i].exp_wr));
      if (vecs[i].exp_wr) check_wq($sformatf("vec%0d word", i), 0, {vecs[i].exp_addr, vecs[i].exp_data});
      check($sformatf("vec%0d frame_err", i), 32'(frame_err), 32'(vecs[i].exp_ferr));
      check($sformatf("vec%0d overflow", i), 32'(overflow), 0);
      clear_err();
      check($sformatf("vec%0d frame_err cleared", i), 32'(frame_err), 0);
      wq.delete();
    end

    // Short then long word: frame error sticks, no writes.
    send_bits(16'h02AA, 10);
    pulse_strobe();
    cyc(4);
    check("t2 short frame_err", 32'(frame_err), 1);
    send_bits(16'h1234, 13);
    pulse_strobe();
    cyc(4);
    check("t2 long frame_err", 32'(frame_err), 1);
    check("t2 write count", 32'(wq.size()), 0);
    clear_err();
    check("t2 frame_err cleared", 32'(frame_err), 0);

    // Overflow: second word dropped while first is held.
    wr.wr_ready = 1'b0;
    send_bits(16'h010F, 11);
    pulse_strobe();
    cyc(4);
    check("t3 A valid", 32'(wr.wr_valid), 1);
    send_bits(16'h02F0, 11);
    pulse_strobe();
    cyc(4);
    check("t3 A held addr", 32'(wr.wr_addr), 1);
    check("t3 A held data", 32'(wr.wr_data), 32'h0F);
    check("t3 overflow", 32'(overflow), 1);
    wr.wr_ready = 1'b1;
    cyc(4);
    check("t3 write count", 32'(wq.size()), 1);
    check_wq("t3 write A", 0, row_word_t'(11'h10F));
    check("t3 idle", 32'(wr.wr_valid), 0);
    clear_err();
    check("t3 overflow cleared", 32'(overflow), 0);
    wq.delete();

    // Back-to-back: ready rises exactly in the cycle B's strobe is seen.
    wr.wr_ready = 1'b0;
    send_bits(16'h010F, 11);
    pulse_strobe();
    cyc(4);
    send_bits(16'h02F0, 11);
    strobe = 1'b1;
    cyc(SYNC_STAGES + 1);
    wr.wr_ready = 1'b1;
    cyc(1);
    check("t4 B valid", 32'(wr.wr_valid), 1);
    check("t4 B addr", 32'(wr.wr_addr), 2);
    check("t4 B data", 32'(wr.wr_data), 32'hF0);
    cyc(1);
    check("t4 B accepted", 32'(wr.wr_valid), 0);
    strobe = 1'b0;
    cyc(HOLD);
    check("t4 write count", 32'(wq.size()), 2);
    check_wq("t4 write A", 0, row_word_t'(11'h10F));
    check_wq("t4 write B", 1, row_word_t'(11'h2F0));
    check("t4 overflow", 32'(overflow), 0);
    wq.delete();

    // Reset mid-word discards partial bits.
    send_bits(16'h002D, 6);
    rst = 1'b1;
    cyc(1);
    check("t5 rst wr_valid", 32'(wr.wr_valid), 0);
    check("t5 rst addr/data", 32'({wr.wr_addr, wr.wr_data}), 0);
    cyc(1);
    rst = 1'b0;
    cyc(1);
    check("t5 post wr_valid", 32'(wr.wr_valid), 0);
    check("t5 post flags", 32'({frame_err, overflow}), 0);
    send_bits(16'h03C3, 11);
    pulse_strobe();
    cyc(4);
    check("t5 write count", 32'(wq.size()), 1);
    check_wq("t5 write", 0, row_word_t'(11'h3C3));
    check("t5 frame_err", 32'(frame_err), 0);
    wq.delete();

    // Disabled block ignores a full word.
    ena = 1'b0;
    send_bits(16'h04E1, 11);
    pulse_strobe();
    cyc(4);
    check("t6 disabled writes", 32'(wq.size()), 0);
    check("t6 disabled flags", 32'({frame_err, overflow}), 0);
    ena = 1'b1;
    send_bits(16'h04E1, 11);
    pulse_strobe();
    cyc(4);
    check("t6 enabled write count", 32'(wq.size()), 1);
    check_wq("t6 write", 0, row_word_t'(11'h4E1));
    check("t6 flags", 32'({frame_err, overflow}), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
